// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
//
// Purpose:
//    Walks every neuron of one network layer after a single start pulse from
//    the network-level controller. For each neuron it clears the MAC, streams
//    num_in weight/activation reads into it, launches the activation unit,
//    waits for its result and writes that result into the opposite ping-pong
//    activation bank. A one-cycle done pulse marks the end of the layer.
//
// Ports:
//    clk        - clock
//    reset      - synchronous, active-high reset; aborts any layer in flight
//    start      - one-cycle launch pulse, only honoured while idle
//    layer      - layer index; bit 0 selects the source activation bank
//    num_in     - inputs per neuron
//    num_out    - neurons in the layer
//    w_base     - first weight RAM address of the layer
//    act_done   - activation unit result valid, only honoured while waiting
//    rd_en      - weight/activation RAM read strobe
//    w_addr     - weight RAM read address
//    x_addr     - activation RAM read address {src_bank, input_idx}
//    mac_clr    - clear the MAC accumulator
//    mac_en     - accumulate RAM read data (rd_en delayed one cycle)
//    act_start  - one-cycle pulse launching the activation unit
//    wr_en      - activation RAM write strobe
//    wr_addr    - activation RAM write address {~src_bank, neuron_idx}
//    busy       - high whenever the sequencer is not idle
//    done       - one-cycle layer-complete pulse
// ---------------------------------------------------------------------------
module layer_sequencer #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        layer,
   input  logic [CNT_W-1:0]  num_in,
   input  logic [CNT_W-1:0]  num_out,
   input  logic [ADDR_W-1:0] w_base,
   input  logic              act_done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] w_addr,
   output logic [CNT_W:0]    x_addr,
   output logic              mac_clr,
   output logic              mac_en,
   output logic              act_start,
   output logic              wr_en,
   output logic [CNT_W:0]    wr_addr,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_MAC,
      S_DRAIN,
      S_ACT,
      S_AWAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              state;

   // Configuration captured when a start is accepted, so the controller may
   // change its inputs freely while the layer runs.
   logic                src_bank;
   logic [CNT_W-1:0]    n_in;
   logic [CNT_W-1:0]    n_out;

   // Weight pointer runs across all neurons of the layer without reloading,
   // because a layer's weights are stored back to back in the weight RAM.
   logic [ADDR_W-1:0]   w_ptr;
   logic [CNT_W-1:0]    in_idx;
   logic [CNT_W-1:0]    neuron_idx;

   // Only the bank-select bit of the layer index matters to this block.
   logic                unused_layer_hi;
   assign unused_layer_hi = layer[1];

   // Single state machine. Every output is a register that is loaded on the
   // transition into the state that owns it, so outputs change exactly when
   // the state does and no input reaches an output combinationally. Pulse
   // outputs default low each cycle and are raised only for their state.
   // mac_en simply follows rd_en one cycle later, matching the one-cycle RAM
   // read latency, which keeps it high through the DRAIN cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         src_bank   <= 1'b0;
         n_in       <= '0;
         n_out      <= '0;
         w_ptr      <= '0;
         in_idx     <= '0;
         neuron_idx <= '0;
         rd_en      <= 1'b0;
         w_addr     <= '0;
         x_addr     <= '0;
         mac_clr    <= 1'b0;
         mac_en     <= 1'b0;
         act_start  <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         rd_en     <= 1'b0;
         mac_clr   <= 1'b0;
         act_start <= 1'b0;
         wr_en     <= 1'b0;
         done      <= 1'b0;
         mac_en    <= rd_en;

         case (state)
            S_IDLE: begin
               if (start) begin
                  src_bank   <= layer[0];
                  n_in       <= num_in;
                  n_out      <= num_out;
                  w_ptr      <= w_base;
                  neuron_idx <= '0;
                  busy       <= 1'b1;
                  // An empty layer finishes at once without touching the RAMs.
                  if ((num_in == '0) || (num_out == '0)) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state   <= S_CLR;
                     mac_clr <= 1'b1;
                  end
               end
            end

            S_CLR: begin
               // Issue the first read of this neuron on the way into MAC.
               state  <= S_MAC;
               in_idx <= '0;
               rd_en  <= 1'b1;
               w_addr <= w_ptr;
               w_ptr  <= w_ptr + ADDR_W'(1);
               x_addr <= {src_bank, {CNT_W{1'b0}}};
            end

            S_MAC: begin
               // in_idx names the read currently on the bus; the next read is
               // only issued while there are inputs left.
               if (in_idx == (n_in - CNT_W'(1))) begin
                  state <= S_DRAIN;
               end else begin
                  in_idx <= in_idx + CNT_W'(1);
                  rd_en  <= 1'b1;
                  w_addr <= w_ptr;
                  w_ptr  <= w_ptr + ADDR_W'(1);
                  x_addr <= {src_bank, in_idx + CNT_W'(1)};
               end
            end

            S_DRAIN: begin
               state     <= S_ACT;
               act_start <= 1'b1;
            end

            S_ACT: begin
               state <= S_AWAIT;
            end

            S_AWAIT: begin
               if (act_done) begin
                  state   <= S_WRITE;
                  wr_en   <= 1'b1;
                  wr_addr <= {~src_bank, neuron_idx};
               end
            end

            S_WRITE: begin
               if (neuron_idx == (n_out - CNT_W'(1))) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  neuron_idx <= neuron_idx + CNT_W'(1);
                  state      <= S_CLR;
                  mac_clr    <= 1'b1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
